// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the instruction memory controller.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // True when a fetch address is misaligned, beyond the array, or past the loaded image.
  function automatic logic fetch_faults(input logic [63:0]   addr,
                                        input logic [63:0]   count,
                                        input int unsigned   aw);
    logic misaligned;
    logic out_of_array;
    logic past_image;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_array = ((addr >> (aw + 32'd2)) != 64'd0);
    past_image   = ((addr >> 2) >= count);
    return misaligned | out_of_array | past_image;
  endfunction

endpackage

// File: rtl/inst_mem_ram.sv
// Single-port word RAM with byte-lane storage; write swizzles into address order, read restores it.
module inst_mem_ram
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 262144,
  parameter int unsigned BIG_ENDIAN  = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // Lane k holds the byte at byte offset k within the word.
  logic [3:0][7:0] mem_q [DEPTH_WORDS];
  logic [31:0]     rdata_q;

  function automatic logic [3:0][7:0] to_lanes(input logic [31:0] w);
    logic [3:0][7:0] lanes;
    for (int k = 0; k < 4; k++) begin
      lanes[k] = (BIG_ENDIAN != 0) ? w[8*(3-k) +: 8] : w[8*k +: 8];
    end
    return lanes;
  endfunction

  function automatic logic [31:0] from_lanes(input logic [3:0][7:0] lanes);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (BIG_ENDIAN != 0) begin
        w[8*(3-k) +: 8] = lanes[k];
      end else begin
        w[8*k +: 8] = lanes[k];
      end
    end
    return w;
  endfunction

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= to_lanes(wdata_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 32'd0;
    end else if (re_i) begin
      rdata_q <= from_lanes(mem_q[addr_i]);
    end
  end

  assign rdata_o = rdata_q;

  logic unused_aw;
  assign unused_aw = (AW == 0);

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory for the fetch stage: streamed image loader plus one-cycle fetch port with fault detection.
module inst_mem_ctrl
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 262144,
  parameter int unsigned BIG_ENDIAN  = 1,
  parameter logic [31:0] FAULT_INST  = NOP_INST
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_reload,
  input  logic                         in_load_valid,
  input  logic [31:0]                  in_load_data,
  input  logic                         in_load_last,
  output logic                         out_load_ready,
  output logic                         out_done_load,
  output logic [$clog2(DEPTH_WORDS):0] out_word_count,
  input  logic                         in_fetch_valid,
  input  logic [63:0]                  in_inst_addr,
  output logic                         out_fetch_ready,
  output logic                         out_inst_valid,
  output logic [31:0]                  out_inst,
  output logic                         out_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            load_ready_q, fetch_ready_q, done_q;
  logic            inst_valid_q, fault_q;

  logic            load_hs, fetch_hs, fault_c;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_rdata;

  assign load_hs  = in_load_valid  & (state_q == LOAD);
  assign fetch_hs = in_fetch_valid & (state_q == READY);
  assign fault_c  = fetch_faults(in_inst_addr, 64'(count_q), AW);

  // Loads and fetches never coexist, so the single port follows the state.
  assign ram_addr = (state_q == LOAD) ? ptr_q : in_inst_addr[2 +: AW];

  // Next-state, pointer and count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    unique case (state_q)
      EMPTY: begin
        if (in_reload) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (in_reload) begin
          ptr_d   = '0;
          count_d = '0;
        end else if (load_hs) begin
          ptr_d   = ptr_q + AW'(1);
          count_d = count_q + CW'(1);
          if (in_load_last || (ptr_q == LAST_IDX)) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        if (in_reload) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q       <= EMPTY;
      ptr_q         <= '0;
      count_q       <= '0;
      load_ready_q  <= 1'b0;
      fetch_ready_q <= 1'b0;
      done_q        <= 1'b0;
      inst_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      load_ready_q  <= (state_d == LOAD);
      fetch_ready_q <= (state_d == READY);
      done_q        <= (state_d == READY);
      inst_valid_q  <= fetch_hs;
      fault_q       <= fetch_hs & fault_c;
    end
  end

  inst_mem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .BIG_ENDIAN  (BIG_ENDIAN)
  ) u_ram (
    .clk_i   (in_clk),
    .rst_i   (in_rst),
    .we_i    (load_hs & ~in_rst),
    .re_i    (fetch_hs & ~in_rst),
    .addr_i  (ram_addr),
    .wdata_i (in_load_data),
    .rdata_o (ram_rdata)
  );

  assign out_load_ready  = load_ready_q;
  assign out_fetch_ready = fetch_ready_q;
  assign out_done_load   = done_q;
  assign out_word_count  = count_q;
  assign out_inst_valid  = inst_valid_q;
  assign out_fault       = fault_q;
  assign out_inst        = fault_q ? FAULT_INST : ram_rdata;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Randomised and directed bench for inst_mem_ctrl with a queue-based scoreboard.
module tb_inst_mem_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int M_EMPTY = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic          clk = 1'b0;
  logic          rst, reload, lvalid, llast, fvalid;
  logic [31:0]   ldata;
  logic [63:0]   faddr;
  logic          load_ready, done_load, fetch_ready, inst_valid, fault;
  logic [AW:0]   word_count;
  logic [31:0]   inst;

  always #5 clk = ~clk;

  inst_mem_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .BIG_ENDIAN  (1),
    .FAULT_INST  (NOP)
  ) dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_reload       (reload),
    .in_load_valid   (lvalid),
    .in_load_data    (ldata),
    .in_load_last    (llast),
    .out_load_ready  (load_ready),
    .out_done_load   (done_load),
    .out_word_count  (word_count),
    .in_fetch_valid  (fvalid),
    .in_inst_addr    (faddr),
    .out_fetch_ready (fetch_ready),
    .out_inst_valid  (inst_valid),
    .out_inst        (inst),
    .out_fault       (fault)
  );

  typedef struct {
    logic [31:0] inst;
    logic        fault;
    int unsigned tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  // Reference model: image as an array of words, a count, and the spec-level mode.
  logic [31:0] m_mem [DEPTH];
  int          m_state = M_EMPTY;
  int unsigned m_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever one is due and checks for stray results.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].tag == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("fetch_valid", 64'(inst_valid), 64'd1);
      if (inst_valid === 1'b1) begin
        chk("fetch_inst", 64'(inst), 64'(e.inst));
        chk("fetch_fault", 64'(fault), 64'(e.fault));
      end
    end else if (inst_valid !== 1'b0) begin
      chk("unexpected_valid", 64'(inst_valid), 64'd0);
    end
  end

  function automatic bit model_fault(input logic [63:0] a);
    longint unsigned ua;
    ua = longint'(a);
    return (ua % 4 != 0) || (ua >= 4 * DEPTH) || (ua / 4 >= m_count);
  endfunction

  // Apply current inputs to the model, clock the DUT, then compare status outputs.
  task automatic step();
    if (rst) begin
      m_state = M_EMPTY;
      m_count = 0;
    end else begin
      if (fvalid && m_state == M_READY) begin
        exp_t e;
        e.fault = model_fault(faddr);
        e.inst  = e.fault ? NOP : m_mem[faddr[2 +: AW]];
        e.tag   = cyc + 1;
        sb.push_back(e);
      end
      if (m_state == M_EMPTY) begin
        if (reload) begin m_state = M_LOAD; m_count = 0; end
      end else if (m_state == M_LOAD) begin
        if (reload) begin
          m_count = 0;
        end else if (lvalid) begin
          m_mem[m_count] = ldata;
          m_count++;
          if (llast || m_count == DEPTH) m_state = M_READY;
        end
      end else begin
        if (reload) begin m_state = M_LOAD; m_count = 0; end
      end
    end
    @(posedge clk);
    #1;
    chk("load_ready", 64'(load_ready), 64'(m_state == M_LOAD));
    chk("fetch_ready", 64'(fetch_ready), 64'(m_state == M_READY));
    chk("done_load", 64'(done_load), 64'(m_state == M_READY));
    chk("word_count", 64'(word_count), 64'(m_count));
  endtask

  task automatic idle();
    rst = 1'b0; reload = 1'b0; lvalid = 1'b0; llast = 1'b0; fvalid = 1'b0;
    ldata = 32'd0; faddr = 64'd0;
  endtask

  task automatic do_reload();
    idle(); reload = 1'b1; step(); idle();
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    idle(); lvalid = 1'b1; ldata = d; llast = last; step(); idle();
  endtask

  task automatic fetch(input logic [63:0] a);
    idle(); fvalid = 1'b1; faddr = a; step(); idle();
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return 64'($urandom_range(0, 4 * DEPTH + 15)) & ~64'h3;
    else if (sel == 7) return 64'($urandom_range(0, 4 * DEPTH)) | 64'($urandom_range(1, 3));
    else if (sel == 8) return {32'($urandom), 32'($urandom)};
    else               return 64'h1 << $urandom_range(AW + 2, 63);
  endfunction

  logic [31:0] prog [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;
    idle();
    rst = 1'b1;
    step(); step();
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    idle();

    // Load the four-word program and fetch it back.
    do_reload();
    for (int i = 0; i < 4; i++) load_word(prog[i], i == 3);
    chk("done_after_last", 64'(done_load), 64'd1);
    chk("count_after_last", 64'(word_count), 64'd4);
    for (int i = 0; i < 4; i++) fetch(64'(4 * i));
    fetch(64'd2);
    fetch(64'd16);
    fetch(64'h1_0000_0000);

    // Overflow the array with no last marker.
    do_reload();
    for (int i = 0; i < DEPTH + 2; i++) load_word($urandom, 1'b0);
    chk("overflow_count", 64'(word_count), 64'(DEPTH));
    fetch(64'(4 * (DEPTH - 1)));
    fetch(64'(4 * DEPTH));

    // Reload in READY with a concurrent fetch.
    do_reload();
    for (int i = 0; i < 4; i++) load_word(prog[i], i == 3);
    idle(); reload = 1'b1; fvalid = 1'b1; faddr = 64'd4; step();
    chk("reload_done", 64'(done_load), 64'd0);
    chk("reload_count", 64'(word_count), 64'd0);
    fetch(64'd0);

    // Reset in the middle of a load.
    for (int i = 0; i < 2; i++) load_word(prog[i], 1'b0);
    idle(); rst = 1'b1; lvalid = 1'b1; ldata = 32'hDEAD_BEEF; step();
    chk("midrst_inst", 64'(inst), 64'd0);
    chk("midrst_fault", 64'(fault), 64'd0);
    idle();
    do_reload();
    load_word(prog[0], 1'b1);
    fetch(64'd4);
    fetch(64'd0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst    = ($urandom_range(0, 399) == 0);
      reload = ($urandom_range(0, 39) == 0);
      lvalid = ($urandom_range(0, 9) < 7);
      ldata  = $urandom;
      llast  = ($urandom_range(0, 7) == 0);
      fvalid = ($urandom_range(0, 9) < 6);
      faddr  = rand_addr();
      step();
    end

    idle();
    step(); step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Synthesizable, parametrised instruction memory for the core's fetch stage. It replaces file-based preloading with a streamed word loader and serves 32-bit instruction fetches at 64-bit byte addresses with one cycle of read latency. Fetches outside the loaded image or not word-aligned raise a fault. A new program can be streamed in at run time without resetting the core.

## Interface
Parameters:
- `DEPTH_WORDS`, 262144: capacity in 32-bit words. Power of two, ≥ 4.
- `BIG_ENDIAN`, 1: 1 places load-word bits [31:24] at the lowest byte address; 0 places bits [7:0] there. Fetch returns the same byte order, so a loaded word reads back unchanged.
- `FAULT_INST`, 32'h0000_0013: value driven on `out_inst` for a faulting fetch (NOP).

Ports:
- `in_clk` input 1: clock. All logic is on the rising edge.
- `in_rst` input 1: synchronous, active-high reset.
- `in_reload` input 1: one-cycle pulse that starts a new load.
- `in_load_valid` input 1: load word valid.
- `in_load_data` input 32: load word.
- `in_load_last` input 1: marks the final word of the image.
- `out_load_ready` output 1: loader can accept a word.
- `out_done_load` output 1: image is loaded and fetches are served.
- `out_word_count` output log2(DEPTH_WORDS)+1: number of words loaded.
- `in_fetch_valid` input 1: fetch request.
- `in_inst_addr` input 64: fetch byte address.
- `out_fetch_ready` output 1: fetch request can be accepted.
- `out_inst_valid` output 1: `out_inst` and `out_fault` are valid.
- `out_inst` output 32: fetched instruction.
- `out_fault` output 1: fetch was misaligned or outside the loaded image.

## Operation
- FSM states:
  - `EMPTY` (reset state): no image present.
  - `LOAD`: streaming words in.
  - `READY`: serving fetches.
- Transitions:
  - EMPTY→LOAD when `in_reload` is sampled high.
  - LOAD→READY on the cycle after a load handshake with `in_load_last`=1, or after the handshake that writes word DEPTH_WORDS−1.
  - READY→LOAD on `in_reload`.
  - `in_reload` while in LOAD restarts the load: pointer and count return to 0.
- `out_load_ready` = (state==LOAD). `out_fetch_ready` = (state==READY). `out_done_load` = (state==READY).
- Load handshake is `in_load_valid & out_load_ready`. On each handshake:
  - `in_load_data` is written at word index = pointer.
  - pointer and `out_word_count` increment by 1.
- Entering LOAD clears the pointer and `out_word_count` to 0. Memory contents are not cleared.
- Fetch handshake is `in_fetch_valid & out_fetch_ready`. Word index = `in_inst_addr[2+:log2(DEPTH_WORDS)]`.
- Fault rule: `out_fault`=1 when any of the following holds; `out_inst` is then `FAULT_INST`:
  - `in_inst_addr[1:0]` ≠ 0;
  - `in_inst_addr` ≥ 4·DEPTH_WORDS (any set upper bit);
  - word index ≥ `out_word_count`.
- Address compare uses the full 64 bits. The count compare is unsigned.
- Reset, any state: state→EMPTY; pointer=0; `out_word_count`=0; `out_inst_valid`=0; `out_inst`=0; `out_fault`=0; `out_done_load`=0; both readies 0. RAM contents are undefined after power-up and untouched by reset.

## Timing
- Load: one word per cycle at full throughput. A write is visible to fetches in READY with no hazard, because writes and reads never overlap in time.
- Fetch latency is exactly 1 cycle: handshake at edge N → `out_inst_valid`=1 with data after edge N. The result holds for one cycle only; there is no stall input.
- Back-to-back fetches are accepted every cycle.
- When `in_reload` and a fetch handshake occur in the same READY cycle:
  - the fetch completes normally in the next cycle;
  - the state becomes LOAD in the next cycle.
- When `in_rst` and a handshake occur in the same cycle, reset wins and the handshake has no effect.
- `in_load_last` on the word at index DEPTH_WORDS−1 causes a single transition, not a double one.
- Load words offered in EMPTY or READY are ignored (ready is 0).

## Structure
- Package `inst_mem_pkg` holds:
  - the state enum (`EMPTY`, `LOAD`, `READY`);
  - the default NOP constant;
  - a function that checks the fault conditions for an address against a count.
- Sub-module `inst_mem_ram`: single-port RAM, 32-bit words, synchronous write, synchronous (registered) read, DEPTH_WORDS entries. Byte-order swizzling on the write path is controlled by `BIG_ENDIAN`.
- FSM, pointer, counter and fault logic live in `inst_mem_ctrl`. `out_fault` is registered in parallel with the RAM read.

## Test plan
- Reset, pulse reload, stream 4 words 0x00500093, 0x00100113, 0x002081B3, 0x00000013 (last on the 4th) → `out_done_load`=1 one cycle after the last handshake; `out_word_count`=4.
- Fetch addresses 0, 4, 8, 12 back-to-back → `out_inst` sequence matches the loaded words, each 1 cycle after its request, `out_fault`=0.
- Fetch address 2, address 16, and address 0x1_0000_0000 → `out_fault`=1, `out_inst`=0x00000013.
- With DEPTH_WORDS=4, stream 6 words with no last → ready drops after the 4th word; the 5th and 6th are not accepted; count=4.
- Reload during READY with a simultaneous fetch of address 4 → fetch returns 0x00100113; the next cycle `out_done_load`=0 and count=0. A fetch issued there is not accepted.
- Assert `in_rst` mid-load after 2 words → all outputs 0, state EMPTY; after reload and a 1-word image, a fetch of address 4 faults.
